// File: rtl/odo_pkg.sv
// Shared widths, result-entry layout and the target-hit compare used by the result sink.
package odo_pkg;

    localparam int STATE_W = 640;
    localparam int WORD_W  = 32;
    localparam int NONCE_W = 32;
    localparam int DROP_W  = 16;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [DROP_W-1:0]  drop_t;

    typedef struct packed {
        logic [STATE_W-1:0] data;
        nonce_t             nonce;
        logic               hit;
    } result_t;

    // The top word of the cipher state is the figure of merit; lower is better.
    function automatic logic is_hit(input logic [STATE_W-1:0] state,
                                    input logic [WORD_W-1:0]  target);
        return state[STATE_W-1 -: WORD_W] <= target;
    endfunction

endpackage

// File: rtl/odo_result_sink_if.sv
// Result path bundle: encryptor strobe and target in, FIFO head and host handshake out.
interface odo_result_sink_if;
    import odo_pkg::*;

    logic [STATE_W-1:0] in;
    logic               write;
    logic [WORD_W-1:0]  target;
    logic [STATE_W-1:0] out;
    nonce_t             out_nonce;
    logic               out_hit;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in, write, target, out_ready,
        input  out, out_nonce, out_hit, out_valid
    );

    modport slave (
        input  in, write, target, out_ready,
        output out, out_nonce, out_hit, out_valid
    );

endinterface

// File: rtl/odo_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible whenever empty=0.
module odo_result_fifo
    import odo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    result_t mem_q [DEPTH];
    result_t mem_d [DEPTH];
    logic    push_ok;
    logic    pop_ok;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d                = wr_ptr_q + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/odo_result_sink.sv
// Tags encryptor results with a nonce, filters target hits and queues them for the host,
// counting results lost to a full queue.
module odo_result_sink
    import odo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit HITS_ONLY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    odo_result_sink_if.slave     sink,
    input  logic                 clear,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_count
);

    nonce_t  nonce_q, nonce_d;
    logic    s1_valid_q, s1_valid_d;
    result_t s1_entry_q, s1_entry_d;
    logic    overflow_q, overflow_d;
    drop_t   drop_count_q, drop_count_d;

    result_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push_req;
    logic    pop;
    logic    drop;

    assign pop      = sink.out_ready && !fifo_empty;
    assign push_req = s1_valid_q && (s1_entry_q.hit || !HITS_ONLY);
    // A push into a full queue survives only when the host frees a slot this cycle.
    assign drop     = push_req && fifo_full && !pop;

    // NOTE: every signal gets its default first, so no path leaves a latch behind.
    always_comb begin
        nonce_d      = nonce_q;
        s1_valid_d   = sink.write;
        s1_entry_d   = s1_entry_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (sink.write) begin
            s1_entry_d.data  = sink.in;
            s1_entry_d.nonce = nonce_q;
            s1_entry_d.hit   = is_hit(sink.in, sink.target);
            nonce_d          = nonce_q + nonce_t'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + drop_t'(1);
            end
        end

        if (clear) begin
            nonce_d      = '0;
            s1_valid_d   = 1'b0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nonce_q      <= '0;
            s1_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            nonce_q      <= nonce_d;
            s1_valid_q   <= s1_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_entry_q <= s1_entry_d;
    end

    odo_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (push_req),
        .push_data (s1_entry_q),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Tag fields read zero while empty so stale storage never leaks out.
    assign sink.out       = head.data;
    assign sink.out_nonce = fifo_empty ? '0 : head.nonce;
    assign sink.out_hit   = !fifo_empty && head.hit;
    assign sink.out_valid = !fifo_empty;
    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_odo_result_sink.sv
// Directed bench: a hits-only and an enqueue-all sink share stimulus and are checked
// against hand-computed nonces, flags and drop counts.
module tb_odo_result_sink;
    import odo_pkg::*;

    logic               clk = 1'b0;
    logic               reset_s;
    logic               clear_s;
    logic [STATE_W-1:0] in_s;
    logic               write_s;
    logic [WORD_W-1:0]  target_s;
    logic               ready_s;

    logic               ovf_h, ovf_a;
    logic [DROP_W-1:0]  drops_h, drops_a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    odo_result_sink_if if_h ();
    odo_result_sink_if if_a ();

    assign if_h.in        = in_s;
    assign if_h.write     = write_s;
    assign if_h.target    = target_s;
    assign if_h.out_ready = ready_s;
    assign if_a.in        = in_s;
    assign if_a.write     = write_s;
    assign if_a.target    = target_s;
    assign if_a.out_ready = ready_s;

    odo_result_sink #(.DEPTH(4), .HITS_ONLY(1'b1)) u_dut_h (
        .clk        (clk),
        .reset      (reset_s),
        .sink       (if_h.slave),
        .clear      (clear_s),
        .overflow   (ovf_h),
        .drop_count (drops_h)
    );

    odo_result_sink #(.DEPTH(4), .HITS_ONLY(1'b0)) u_dut_a (
        .clk        (clk),
        .reset      (reset_s),
        .sink       (if_a.slave),
        .clear      (clear_s),
        .overflow   (ovf_a),
        .drop_count (drops_a)
    );

    task automatic check(input string tag, input logic [STATE_W-1:0] got,
                         input logic [STATE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] make_state(input logic [WORD_W-1:0] top);
        return {top, {19{top ^ 32'h5A5A_5A5A}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [WORD_W-1:0] top);
        in_s    = make_state(top);
        write_s = 1'b1;
        tick();
        write_s = 1'b0;
    endtask

    task automatic do_reset();
        reset_s = 1'b1;
        tick();
        reset_s = 1'b0;
    endtask

    initial begin
        reset_s  = 1'b1;
        clear_s  = 1'b0;
        in_s     = '0;
        write_s  = 1'b0;
        target_s = 32'h0000_FFFF;
        ready_s  = 1'b0;
        tick();
        tick();
        reset_s = 1'b0;

        check("rst_valid", if_h.out_valid, 0);
        check("rst_hit",   if_h.out_hit,   0);
        check("rst_nonce", if_h.out_nonce, 0);
        check("rst_ovf",   ovf_a,          0);
        check("rst_drops", drops_a,        0);

        // Single hit: visible two cycles after the write cycle.
        do_write(32'h0000_1234);
        check("lat_n1_valid", if_h.out_valid, 0);
        tick();
        check("lat_n2_valid", if_h.out_valid, 1);
        check("lat_nonce",    if_h.out_nonce, 0);
        check("lat_hit",      if_h.out_hit,   1);
        check("lat_data",     if_h.out,       make_state(32'h0000_1234));
        tick();
        tick();
        check("hold_nonce", if_h.out_nonce, 0);
        check("hold_data",  if_h.out,       make_state(32'h0000_1234));
        ready_s = 1'b1;
        tick();
        ready_s = 1'b0;
        check("pop_empty", if_h.out_valid, 0);

        // Filter: only the middle write hits; non-hits are not drops.
        do_reset();
        do_write(32'hFFFF_FFFF);
        do_write(32'h0000_0001);
        do_write(32'h0001_0000);
        tick();
        check("filt_valid",  if_h.out_valid, 1);
        check("filt_nonce",  if_h.out_nonce, 1);
        check("filt_drops",  drops_h,        0);
        check("all_nonce0",  if_a.out_nonce, 0);
        check("all_hit0",    if_a.out_hit,   0);
        ready_s = 1'b1;
        tick();
        ready_s = 1'b0;
        check("filt_single", if_h.out_valid, 0);
        check("all_nonce1",  if_a.out_nonce, 1);
        check("all_hit1",    if_a.out_hit,   1);

        // Overflow: six writes into a depth-4 queue with no reader.
        do_reset();
        for (int i = 0; i < 6; i++) do_write(32'h1000_0000 + i);
        tick();
        tick();
        check("ovf_flag",   ovf_a,   1);
        check("ovf_drops",  drops_a, 2);
        check("ovf_h_flag", ovf_h,   0);
        check("ovf_h_drop", drops_h, 0);
        ready_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), if_a.out_valid, 1);
            check($sformatf("drain_nonce%0d", i), if_a.out_nonce, i);
            tick();
        end
        ready_s = 1'b0;
        check("drain_empty", if_a.out_valid, 0);

        // Full queue: pop coincides with a push, nothing is lost.
        for (int i = 0; i < 5; i++) do_write(32'h2000_0000 + i);
        ready_s = 1'b1;
        tick();
        ready_s = 1'b0;
        check("full_drops",   drops_a,        2);
        check("full_ovf",     ovf_a,          1);
        check("full_head",    if_a.out_nonce, 7);
        ready_s = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            check($sformatf("full_order%0d", i), if_a.out_nonce, i);
            tick();
        end
        ready_s = 1'b0;
        check("full_empty", if_a.out_valid, 0);

        // Clear with two queued entries and a concurrent write.
        do_write(32'h0000_0010);
        do_write(32'h0000_0011);
        tick();
        check("pre_clr_nonce",  if_a.out_nonce, 11);
        check("pre_clr_hnonce", if_h.out_nonce, 11);
        clear_s = 1'b1;
        in_s    = make_state(32'h0000_0012);
        write_s = 1'b1;
        tick();
        clear_s = 1'b0;
        write_s = 1'b0;
        check("clr_valid", if_a.out_valid, 0);
        check("clr_ovf",   ovf_a,          0);
        check("clr_drops", drops_a,        0);
        check("clr_hvalid", if_h.out_valid, 0);
        tick();
        tick();
        check("clr_wr_lost", if_a.out_valid, 0);
        do_write(32'h0000_0013);
        tick();
        check("clr_next_valid",  if_a.out_valid, 1);
        check("clr_next_nonce",  if_a.out_nonce, 0);
        check("clr_next_hnonce", if_h.out_nonce, 0);

        // Reset while stage 1 holds a hit: nothing must ever surface.
        do_write(32'h0000_0020);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_mid_h%0d", i), if_h.out_valid, 0);
            check($sformatf("rst_mid_a%0d", i), if_a.out_valid, 0);
            tick();
        end
        check("rst_mid_hit",   if_h.out_hit,   0);
        check("rst_mid_nonce", if_h.out_nonce, 0);
        check("rst_mid_drops", drops_a,        0);
        do_write(32'h0000_0030);
        tick();
        check("post_rst_valid", if_h.out_valid, 1);
        check("post_rst_nonce", if_h.out_nonce, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
